// File: rtl/vx_cluster_ctrl.sv
// vx_cluster_ctrl: cluster-level control for NUM_SOCKETS sockets.
//   - Forwards base-range DCR writes to the sockets enabled in socket_mask,
//     through DCR_STAGES register stages (0 = combinational path).
//   - Aggregates per-socket busy into a debounced cluster busy.
//   - Runs the host quiesce handshake (halt sockets, wait for drain, ack).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dcr_wr_valid/addr/data     cluster DCR write input
//   sock_dcr_valid/addr/data   per-socket strobe vector, shared addr/data
//   socket_mask                current socket enable mask
//   per_socket_busy, busy      raw socket busy in, debounced busy out
//   quiesce_req                host level request to halt and drain
//   socket_halt, quiesce_ack   per-socket halt, cluster halted-and-idle
module vx_cluster_ctrl #(
  parameter int unsigned NUM_SOCKETS = 4,
  parameter int unsigned DCR_ADDR_W  = 12,
  parameter int unsigned DCR_DATA_W  = 32,
  parameter logic [DCR_ADDR_W-1:0] BASE_BEGIN = DCR_ADDR_W'('h001),
  parameter logic [DCR_ADDR_W-1:0] BASE_END   = DCR_ADDR_W'('h020),
  parameter logic [DCR_ADDR_W-1:0] MASK_ADDR  = DCR_ADDR_W'('h0FF),
  parameter int unsigned DCR_STAGES  = 1,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dcr_wr_valid,
  input  logic [DCR_ADDR_W-1:0]  dcr_wr_addr,
  input  logic [DCR_DATA_W-1:0]  dcr_wr_data,
  output logic [NUM_SOCKETS-1:0] sock_dcr_valid,
  output logic [DCR_ADDR_W-1:0]  sock_dcr_addr,
  output logic [DCR_DATA_W-1:0]  sock_dcr_data,
  output logic [NUM_SOCKETS-1:0] socket_mask,
  input  logic [NUM_SOCKETS-1:0] per_socket_busy,
  output logic                   busy,
  input  logic                   quiesce_req,
  output logic [NUM_SOCKETS-1:0] socket_halt,
  output logic                   quiesce_ack
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HALT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic                   mask_wr_c;
  logic                   fwd_c;
  logic                   pipe_occ_c;
  logic                   pending_c;

  logic [NUM_SOCKETS-1:0] socket_mask_q, socket_mask_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                   busy_q, busy_d;
  state_e                 state_q, state_d;
  logic [NUM_SOCKETS-1:0] halt_q, halt_d;
  logic                   ack_q, ack_d;

  // DCR decode; the mask register wins over an overlapping base range
  always_comb begin
    mask_wr_c = dcr_wr_valid && (dcr_wr_addr == MASK_ADDR);
    fwd_c     = dcr_wr_valid && !mask_wr_c &&
                (dcr_wr_addr >= BASE_BEGIN) && (dcr_wr_addr < BASE_END);
  end

  // Socket enable mask
  always_comb begin
    socket_mask_d = socket_mask_q;
    if (mask_wr_c) socket_mask_d = NUM_SOCKETS'(dcr_wr_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) socket_mask_q <= '1;
    else       socket_mask_q <= socket_mask_d;
  end

  // Forwarding path. occ tracks accepted writes even when the mask is zero,
  // so a consumed-but-strobeless write still holds off the quiesce ack.
  if (DCR_STAGES == 0) begin : g_comb
    assign sock_dcr_valid = fwd_c ? socket_mask_q : '0;
    assign sock_dcr_addr  = dcr_wr_addr;
    assign sock_dcr_data  = dcr_wr_data;
    assign pipe_occ_c     = 1'b0;
  end else begin : g_pipe
    logic [NUM_SOCKETS-1:0] vld_q  [DCR_STAGES];
    logic [NUM_SOCKETS-1:0] vld_d  [DCR_STAGES];
    logic [DCR_ADDR_W-1:0]  addr_q [DCR_STAGES];
    logic [DCR_ADDR_W-1:0]  addr_d [DCR_STAGES];
    logic [DCR_DATA_W-1:0]  data_q [DCR_STAGES];
    logic [DCR_DATA_W-1:0]  data_d [DCR_STAGES];
    logic [DCR_STAGES-1:0]  occ_q, occ_d;

    always_comb begin
      vld_d[0]  = fwd_c ? socket_mask_q : '0;
      addr_d[0] = dcr_wr_addr;
      data_d[0] = dcr_wr_data;
      occ_d     = '0;
      occ_d[0]  = fwd_c;
      for (int i = 1; i < int'(DCR_STAGES); i++) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
        data_d[i] = data_q[i-1];
        occ_d[i]  = occ_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q  <= '{default: '0};
        addr_q <= '{default: '0};
        data_q <= '{default: '0};
        occ_q  <= '0;
      end else begin
        vld_q  <= vld_d;
        addr_q <= addr_d;
        data_q <= data_d;
        occ_q  <= occ_d;
      end
    end

    assign sock_dcr_valid = vld_q[DCR_STAGES-1];
    assign sock_dcr_addr  = addr_q[DCR_STAGES-1];
    assign sock_dcr_data  = data_q[DCR_STAGES-1];
    assign pipe_occ_c     = |occ_q;
  end

  assign pending_c = fwd_c | pipe_occ_c;

  // Busy debounce: rise immediately, fall after IDLE_CYCLES idle cycles
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    busy_d     = busy_q;
    if (|per_socket_busy) begin
      busy_d     = 1'b1;
      idle_cnt_d = '0;
    end else if (idle_cnt_q < IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
      if (idle_cnt_d == IDLE_MAX) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Quiesce FSM; halt/ack registered from the next state so they track it
  always_comb begin
    state_d = state_q;
    halt_d  = '0;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (quiesce_req) state_d = ST_HALT;
      ST_HALT: begin
        if (!quiesce_req)                 state_d = ST_IDLE;
        else if (!busy_q && !pending_c)   state_d = ST_DONE;
      end
      ST_DONE: if (!quiesce_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_IDLE) halt_d = socket_mask_d;
    ack_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      halt_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      ack_q   <= ack_d;
    end
  end

  assign socket_mask = socket_mask_q;
  assign busy        = busy_q;
  assign socket_halt = halt_q;
  assign quiesce_ack = ack_q;

endmodule

// File: tb/tb_vx_cluster_ctrl.sv
// Bench for vx_cluster_ctrl: two instances (1 and 3 forwarding stages) share
// stimulus; expected strobes are queued at drive time and popped by monitors.
module tb_vx_cluster_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] MASK_A = 12'h0FF;

  logic          clk = 1'b0;
  logic          reset;
  logic          dcr_wr_valid;
  logic [AW-1:0] dcr_wr_addr;
  logic [DW-1:0] dcr_wr_data;
  logic [NS-1:0] per_socket_busy;
  logic          quiesce_req;

  logic [NS-1:0] v1, m1, h1, v3, m3, h3;
  logic [AW-1:0] a1, a3;
  logic [DW-1:0] d1, d3;
  logic          b1, k1, b3, k3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int            cyc;
    logic [NS-1:0] vec;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q1[$];
  exp_t          q3[$];
  logic [NS-1:0] model_mask;

  vx_cluster_ctrl #(.NUM_SOCKETS(NS), .DCR_ADDR_W(AW), .DCR_DATA_W(DW),
                    .DCR_STAGES(1), .IDLE_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .sock_dcr_valid(v1), .sock_dcr_addr(a1), .sock_dcr_data(d1),
    .socket_mask(m1), .per_socket_busy(per_socket_busy), .busy(b1),
    .quiesce_req(quiesce_req), .socket_halt(h1), .quiesce_ack(k1));

  vx_cluster_ctrl #(.NUM_SOCKETS(NS), .DCR_ADDR_W(AW), .DCR_DATA_W(DW),
                    .DCR_STAGES(3), .IDLE_CYCLES(4)) dut3 (
    .clk(clk), .reset(reset),
    .dcr_wr_valid(dcr_wr_valid), .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data),
    .sock_dcr_valid(v3), .sock_dcr_addr(a3), .sock_dcr_data(d3),
    .socket_mask(m3), .per_socket_busy(per_socket_busy), .busy(b3),
    .quiesce_req(quiesce_req), .socket_halt(h3), .quiesce_ack(k3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one DCR write for one cycle and queue its expected strobes
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    if (a == MASK_A) begin
      model_mask = NS'(d);
    end else if (a >= 12'h001 && a < 12'h020 && model_mask != '0) begin
      e = '{cyc + 1, model_mask, a, d};
      q1.push_back(e);
      e.cyc = cyc + 3;
      q3.push_back(e);
    end
    tick();
    dcr_wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() != 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk("s1_valid", 64'(v1), 64'(e.vec));
      chk("s1_addr",  64'(a1), 64'(e.addr));
      chk("s1_data",  64'(d1), 64'(e.data));
    end else begin
      chk("s1_no_strobe", 64'(v1), 64'(0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q3.size() != 0 && q3[0].cyc == cyc) begin
      e = q3.pop_front();
      chk("s3_valid", 64'(v3), 64'(e.vec));
      chk("s3_addr",  64'(a3), 64'(e.addr));
      chk("s3_data",  64'(d3), 64'(e.data));
    end else begin
      chk("s3_no_strobe", 64'(v3), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int first1;
    int first3;

    reset = 1'b1;
    dcr_wr_valid = 1'b0;
    dcr_wr_addr = '0;
    dcr_wr_data = '0;
    per_socket_busy = '0;
    quiesce_req = 1'b0;
    model_mask = '1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_mask1", 64'(m1), 64'hF);
    chk("rst_mask3", 64'(m3), 64'hF);
    chk("rst_busy",  64'({b1, b3}), 64'(0));
    chk("rst_halt",  64'({h1, h3}), 64'(0));
    chk("rst_ack",   64'({k1, k3}), 64'(0));

    // Single base write with full mask
    wr(12'h005, 32'hAB);
    repeat (4) tick();

    // Mask write then base write on the next cycle, then out-of-range write
    wr(MASK_A, 32'h5);
    wr(12'h010, 32'h1234);
    wr(12'h030, 32'h5555);
    tick();
    chk("mask_after_wr1", 64'(m1), 64'h5);
    chk("mask_after_wr3", 64'(m3), 64'h5);

    // Range boundaries, back-to-back
    wr(12'h000, 32'h10);
    wr(12'h001, 32'h11);
    wr(12'h01F, 32'h12);
    wr(12'h020, 32'h13);
    wr(12'h0FE, 32'h14);
    repeat (4) tick();

    // Zero mask consumes the write silently
    wr(MASK_A, 32'h0);
    wr(12'h008, 32'h77);
    tick();
    chk("mask_zero", 64'(m1), 64'h0);
    wr(MASK_A, 32'h9);
    repeat (4) tick();

    // Busy rise and debounce
    per_socket_busy = 4'b0010;
    tick();
    chk("busy_rise", 64'(b1), 64'(1));
    tick();
    tick();
    per_socket_busy = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("busy_fall_timing", 64'(b1), 64'(i < 4));
    end
    chk("busy_fall3", 64'(b3), 64'(0));

    // Short idle gap does not lower busy
    per_socket_busy = 4'b0100;
    repeat (3) tick();
    per_socket_busy = '0;
    tick();
    chk("glitch_a", 64'(b1), 64'(1));
    tick();
    chk("glitch_b", 64'(b1), 64'(1));
    per_socket_busy = 4'b0001;
    tick();
    chk("glitch_c", 64'(b1), 64'(1));

    // Quiesce while busy
    quiesce_req = 1'b1;
    tick();
    chk("q_halt", 64'(h1), 64'(model_mask));
    chk("q_ack_busy", 64'(k1), 64'(0));
    repeat (3) tick();
    chk("q_ack_still0", 64'(k1), 64'(0));
    wr(MASK_A, 32'h6);
    chk("q_halt_live", 64'(h1), 64'h6);
    per_socket_busy = '0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n = i;
      if (k1) break;
    end
    chk("q_ack_delay", 64'(n), 64'(5));
    chk("q_ack3", 64'(k3), 64'(1));
    chk("q_halt_done", 64'(h1), 64'h6);
    quiesce_req = 1'b0;
    tick();
    chk("q_release_halt", 64'({h1, h3}), 64'(0));
    chk("q_release_ack",  64'({k1, k3}), 64'(0));
    tick();

    // Base write and quiesce in the same cycle, all sockets idle
    k = cyc;
    quiesce_req = 1'b1;
    wr(12'h003, 32'hC0DE);
    first1 = -1;
    first3 = -1;
    for (int i = 0; i < 12; i++) begin
      if (k1 && first1 < 0) first1 = cyc;
      if (k3 && first3 < 0) first3 = cyc;
      if (cyc <= k + 3) chk("pipe_ack3_early", 64'(k3), 64'(0));
      tick();
    end
    chk("pipe_ack1_after", 64'(first1 > k + 1), 64'(1));
    chk("pipe_ack3_after", 64'(first3 > k + 3), 64'(1));
    chk("pipe_ack3_seen",  64'(k3), 64'(1));
    quiesce_req = 1'b0;
    repeat (2) tick();

    // Reset with two writes in flight, busy set and FSM halted
    wr(MASK_A, 32'h3);
    per_socket_busy = 4'b1000;
    quiesce_req = 1'b1;
    repeat (2) tick();
    chk("pre_rst_busy", 64'(b3), 64'(1));
    chk("pre_rst_halt", 64'(h3), 64'h3);
    wr(12'h002, 32'hD1);
    wr(12'h004, 32'hD2);
    reset = 1'b1;
    q1.delete();
    q3.delete();
    model_mask = '1;
    #1;
    chk("mid_rst_busy", 64'({b1, b3}), 64'(0));
    chk("mid_rst_mask", 64'({m1, m3}), 64'hFF);
    chk("mid_rst_halt", 64'({h1, h3}), 64'(0));
    chk("mid_rst_valid", 64'({v1, v3}), 64'(0));
    per_socket_busy = '0;
    quiesce_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("post_rst_halt", 64'({h1, h3}), 64'(0));
    chk("post_rst_ack",  64'({k1, k3}), 64'(0));
    chk("post_rst_busy", 64'({b1, b3}), 64'(0));
    chk("post_rst_mask", 64'(m3), 64'hF);

    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("q3_drained", 64'(q3.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
